// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared types and helpers for the soc_mem_xbar memory front-end.
package soc_mem_pkg;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
    localparam int PORT_ID_W = 3;   // enough for up to 8 requester ports
    localparam int MAX_DW    = 512; // widest data path the mask helper handles

    typedef enum logic {
        TGT_SRAM = 1'b0,
        TGT_MMIO = 1'b1
    } target_e;

    typedef struct packed {
        logic                 valid;
        logic [PORT_ID_W-1:0] port_id;
        logic                 is_write;
    } resp_pipe_t;

    // Expand byte strobes into a per-bit write mask (each strobe covers 8 bits).
    function automatic logic [MAX_DW-1:0] strb_to_mask(input logic [MAX_DW/8-1:0] strb);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DW/8; i++) m[i*8 +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/soc_mem_xbar_if.sv
// soc_mem_xbar_if: core-side request/response bundle for all requester ports.
// master = requesters (cores, debug), slave = the crossbar.
interface soc_mem_xbar_if #(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64
);
    logic [NumPorts-1:0]                    port_req_i;
    logic [NumPorts-1:0]                    port_gnt_o;
    logic [NumPorts-1:0][AddrWidth-1:0]     port_addr_i;
    logic [NumPorts-1:0]                    port_we_i;
    logic [NumPorts-1:0][DataWidth-1:0]     port_wdata_i;
    logic [NumPorts-1:0][DataWidth/8-1:0]   port_strb_i;
    logic [NumPorts-1:0]                    port_rvalid_o;
    logic [NumPorts-1:0][DataWidth-1:0]     port_rdata_o;

    modport master (
        output port_req_i, port_addr_i, port_we_i, port_wdata_i, port_strb_i,
        input  port_gnt_o, port_rvalid_o, port_rdata_o
    );

    modport slave (
        input  port_req_i, port_addr_i, port_we_i, port_wdata_i, port_strb_i,
        output port_gnt_o, port_rvalid_o, port_rdata_o
    );
endinterface

// File: rtl/soc_mem_xbar_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; the search starts at the pointer,
// which moves to winner+1 only when the grant is actually taken.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    input  logic         accept
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] win;
    logic          found;
    int            j;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                win    = IW'(j);
            end
        end
    end

    // Pointer update; holds while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/soc_mem_xbar.sv
// soc_mem_xbar: N-port front-end to the word-addressed SRAM and the MMIO bus.
// Address decode, per-target round-robin, SRAM relocation/word alignment and
// per-target response return (SRAM: MemReadLatency cycles, MMIO: 1 cycle).
// Optional build macro SOC_MEM_XBAR_MMIO_READ_TRAP_EN: MMIO reads are not
// forwarded; they answer all-ones and set the sticky mmio_rd_err_o flag.
module soc_mem_xbar
    import soc_mem_pkg::*;
#(
    parameter int unsigned          NumPorts       = 2,
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 64,
    parameter logic [AddrWidth-1:0] MemBase        = MEM_BASE_DEFAULT,
    parameter int unsigned          NumWords       = 1 << 20,
    parameter int unsigned          MemReadLatency = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    soc_mem_xbar_if.slave          port,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth-1:0]   mem_wmask_o,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   mmio_req_o,
    output logic                   mmio_we_o,
    output logic [AddrWidth-1:0]   mmio_addr_o,
    output logic [DataWidth-1:0]   mmio_wdata_o,
    output logic [DataWidth/8-1:0] mmio_strb_o,
    input  logic [DataWidth-1:0]   mmio_rdata_i,
    output logic                   mmio_rd_err_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffsBits  = $clog2(StrbWidth);
    // Window bounds carry one extra bit so MemBase + size cannot wrap.
    localparam logic [AddrWidth:0] MemLo   = {1'b0, MemBase};
    localparam logic [AddrWidth:0] MemSize = (AddrWidth+1)'(NumWords) * (AddrWidth+1)'(StrbWidth);
    localparam logic [AddrWidth:0] MemHi   = MemLo + MemSize;

    target_e              tgt [NumPorts];
    logic [NumPorts-1:0]  elig, sram_req, mmio_req, sram_gnt, mmio_gnt;
    logic [NumPorts-1:0]  outst_q, rvalid;
    logic [NumPorts-1:0][DataWidth-1:0] rdata;
    logic [AddrWidth:0]   ext_addr;

    // SRAM winner fields
    logic [AddrWidth-1:0] s_addr, s_word;
    logic                 s_we;
    logic [DataWidth-1:0] s_wdata, s_mask;
    logic [StrbWidth-1:0] s_strb;
    logic [PORT_ID_W-1:0] s_id;
    logic [MAX_DW/8-1:0]  strb_wide;
    logic [MAX_DW-1:0]    mask_wide;

    // MMIO winner fields
    logic [AddrWidth-1:0] m_addr;
    logic                 m_we, m_gnt_any;
    logic [DataWidth-1:0] m_wdata, m_rd_data;
    logic [StrbWidth-1:0] m_strb;
    logic [PORT_ID_W-1:0] m_id;

    // Held target fields for cycles without a grant
    logic [AddrWidth-1:0] mem_addr_q, mmio_addr_q;
    logic [DataWidth-1:0] mem_wdata_q, mem_wmask_q, mmio_wdata_q, mmio_rdata_q;
    logic [StrbWidth-1:0] mmio_strb_q;

    resp_pipe_t pipe_q [1:MemReadLatency];
    resp_pipe_t mmio_rsp_q;

    // Decode and eligibility: one transaction in flight per port, but a port
    // whose response is returning this cycle may issue again.
    always_comb begin
        ext_addr = '0;
        for (int p = 0; p < NumPorts; p++) begin
            ext_addr    = {1'b0, port.port_addr_i[p]};
            tgt[p]      = (ext_addr >= MemLo && ext_addr < MemHi) ? TGT_SRAM : TGT_MMIO;
            elig[p]     = !outst_q[p] || rvalid[p];
            sram_req[p] = port.port_req_i[p] && elig[p] && (tgt[p] == TGT_SRAM);
            mmio_req[p] = port.port_req_i[p] && elig[p] && (tgt[p] == TGT_MMIO);
        end
    end

    rr_arbiter #(.N(NumPorts)) u_arb_sram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (sram_req),
        .gnt   (sram_gnt),
        .accept(|sram_gnt)
    );

    rr_arbiter #(.N(NumPorts)) u_arb_mmio (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (mmio_req),
        .gnt   (mmio_gnt),
        .accept(|mmio_gnt)
    );

    // SRAM winner mux, relocation to word index and strobe expansion.
    always_comb begin
        s_addr  = '0;
        s_we    = 1'b0;
        s_wdata = '0;
        s_strb  = '0;
        s_id    = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (sram_gnt[p]) begin
                s_addr  = port.port_addr_i[p];
                s_we    = port.port_we_i[p];
                s_wdata = port.port_wdata_i[p];
                s_strb  = port.port_strb_i[p];
                s_id    = PORT_ID_W'(p);
            end
        end
        s_word    = (s_addr - MemBase) >> OffsBits;
        strb_wide = '0;
        strb_wide[StrbWidth-1:0] = s_strb;
        mask_wide = strb_to_mask(strb_wide);
        s_mask    = mask_wide[DataWidth-1:0];
    end

    // MMIO winner mux.
    always_comb begin
        m_addr  = '0;
        m_we    = 1'b0;
        m_wdata = '0;
        m_strb  = '0;
        m_id    = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (mmio_gnt[p]) begin
                m_addr  = port.port_addr_i[p];
                m_we    = port.port_we_i[p];
                m_wdata = port.port_wdata_i[p];
                m_strb  = port.port_strb_i[p];
                m_id    = PORT_ID_W'(p);
            end
        end
    end

    assign m_gnt_any = |mmio_gnt;

    assign mem_req_o   = |sram_gnt;
    assign mem_we_o    = mem_req_o & s_we;
    assign mem_addr_o  = mem_req_o ? s_word  : mem_addr_q;
    assign mem_wdata_o = mem_req_o ? s_wdata : mem_wdata_q;
    assign mem_wmask_o = mem_req_o ? s_mask  : mem_wmask_q;

    assign mmio_we_o    = m_gnt_any & m_we;
    assign mmio_addr_o  = m_gnt_any ? m_addr  : mmio_addr_q;
    assign mmio_wdata_o = m_gnt_any ? m_wdata : mmio_wdata_q;
    assign mmio_strb_o  = m_gnt_any ? m_strb  : mmio_strb_q;

`ifdef SOC_MEM_XBAR_MMIO_READ_TRAP_EN
    logic rd_err_q;
    logic unused_mmio_rdata;

    // Reads never reach the bus; they are answered locally with all ones.
    assign mmio_req_o        = m_gnt_any & m_we;
    assign m_rd_data         = m_we ? '0 : '1;
    assign mmio_rd_err_o     = rd_err_q;
    assign unused_mmio_rdata = ^mmio_rdata_i;

    // Sticky error flag for any trapped read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_err_q <= 1'b0;
        else if (m_gnt_any && !m_we) rd_err_q <= 1'b1;
    end
`else
    assign mmio_req_o    = m_gnt_any;
    assign m_rd_data     = m_we ? '0 : mmio_rdata_i;
    assign mmio_rd_err_o = 1'b0;
`endif

    // Hold the last target address/data while the target is idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
            mmio_strb_q  <= '0;
        end else begin
            if (mem_req_o) begin
                mem_addr_q  <= s_word;
                mem_wdata_q <= s_wdata;
                mem_wmask_q <= s_mask;
            end
            if (m_gnt_any) begin
                mmio_addr_q  <= m_addr;
                mmio_wdata_q <= m_wdata;
                mmio_strb_q  <= m_strb;
            end
        end
    end

    // SRAM response tracker: valid/ID shift pipeline, MemReadLatency deep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= MemReadLatency; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[1] <= '{valid: mem_req_o, port_id: s_id, is_write: s_we};
            for (int k = 2; k <= MemReadLatency; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    // MMIO response: data captured at acceptance, returned next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mmio_rsp_q   <= '0;
            mmio_rdata_q <= '0;
        end else begin
            mmio_rsp_q <= '{valid: m_gnt_any, port_id: m_id, is_write: m_we};
            if (m_gnt_any) mmio_rdata_q <= m_rd_data;
        end
    end

    // Route responses back to their ports; writes return zero data.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (pipe_q[MemReadLatency].valid && pipe_q[MemReadLatency].port_id == PORT_ID_W'(p)) begin
                rvalid[p] = 1'b1;
                rdata[p]  = pipe_q[MemReadLatency].is_write ? '0 : mem_rdata_i;
            end
            if (mmio_rsp_q.valid && mmio_rsp_q.port_id == PORT_ID_W'(p)) begin
                rvalid[p] = 1'b1;
                rdata[p]  = mmio_rdata_q;
            end
        end
    end

    // Outstanding bit per port: set on accept, cleared by its response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) outst_q <= '0;
        else       outst_q <= (outst_q & ~rvalid) | sram_gnt | mmio_gnt;
    end

    assign port.port_gnt_o    = sram_gnt | mmio_gnt;
    assign port.port_rvalid_o = rvalid;
    assign port.port_rdata_o  = rdata;

endmodule
